id_stage_pipelined: RTL and testbench
=====================================

// Module: id_stage_pipelined
// PURPOSE
//  Parametrised ARM decode stage with the ID/EX pipeline register folded in. Holds the register file with
//  same-cycle write-through bypass, condition check and control decode. Presents registered control/operands
//  to EXE; supports freeze (cache miss), hazard bubble and branch flush. Sits between IF/ID register and EXE.
// PARAMETERS
//  DATA_W     32  register / result / PC width
//  NUM_REGS   16  architectural registers; REG_AW = $clog2(NUM_REGS) (ISA fields fix 4 bits, NUM_REGS<=16)
//  BYPASS_EN  1   1: WB write to a source read in the same cycle forwards Result_WB; 0: old RF value
//  PERF_W     16  width of saturating bubble counter
// PORTS
//  clk                 in   1       clock, all state updates on rising edge
//  rst                 in   1       asynchronous reset, active-high
//  instruction         in   32      instruction from IF/ID
//  PC_in               in   DATA_W  PC+4 of instruction
//  valid_in            in   1       instruction is real (0 = bubble from IF)
//  freeze              in   1       hold all ID/EX outputs (memory stall)
//  hazard              in   1       insert bubble into ID/EX
//  flush               in   1       branch taken in EXE: kill this instruction
//  Status_Reg          in   4       {N,Z,C,V}
//  writeBackEn         in   1       WB write enable
//  Dest_wb             in   4       WB destination
//  Result_WB           in   DATA_W  WB data
//  Reg_File_src_1/_2   out  4       combinational source addresses (to hazard unit)
//  two_src             out  1       combinational: instruction reads Rm/Rd as 2nd source
//  WB_EN,MEM_R_EN,MEM_W_EN,B,S  out 1 each  registered control
//  EXE_CMD             out  4       registered ALU command
//  Val_Rn, Val_Rm      out  DATA_W  registered operands
//  imm, shifter_operand out 1/12    registered I bit, instr[11:0]
//  Signed_imm_24       out  24      registered instr[23:0]
//  RegDest, src1_q, src2_q out 4    registered Rd and source addresses (for forwarding)
//  PC                  out  DATA_W  registered PC_in
//  valid_out           out  1       ID/EX holds a live instruction
//  bubble_cnt          out  PERF_W  saturating count of bubbles inserted (hazard or flush)
// BEHAVIOUR
//  - Reset: all outputs/registers 0, RF entries 0, bubble_cnt 0. Reset mid-freeze clears everything.
//  - Fields: cond=[31:28], I=[25], mode=[27:26], opcode=[24:21], S=[20], Rn=[19:16], Rd=[15:12], Rm=[3:0].
//  - src_2 = Rd when store (mode 01, S=0), else Rm. two_src = 0 for MOV/MVN, else 1.
//  - Decode mode 00: MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100,
//    SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000, CMP 1010->0100, TST 1000->0110;
//    WB=1 except CMP/TST (WB=0, S forced 1). Undefined opcode -> all control 0.
//    mode 01: EXE_CMD 0010; S=1 LDR (MEM_R, WB), S=0 STR (MEM_W). mode 10: B=1, other control 0.
//  - Condition: EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL on Status_Reg; 1111 treated as never.
//  - Kill = ~valid_in | ~cond_pass | hazard | flush: control bits, valid_out loaded 0; data fields still load.
//  - Priority per edge: rst > freeze (hold everything, RF write still performed) > flush > hazard > normal.
//  - Latency: instruction at ID in cycle n -> ID/EX outputs valid after edge n+1 (1 cycle).
//  - RF: write at rising edge when writeBackEn; reads combinational. BYPASS_EN=1 and writeBackEn and
//    Dest_wb==src -> Val captured = Result_WB. Both sources may bypass simultaneously.
//  - bubble_cnt += 1 on each non-frozen edge where hazard|flush kills a valid_in; saturates at all-ones.
// STRUCTURE
//  - Package id_pkg: EXE_CMD localparams, opcode/cond encodings, mode constants, decoded-control struct.
//  - One sub-module: id_regfile (NUM_REGS x DATA_W, async reset, bypass). Decode/cond-check inline.
// TESTING
//  - Reset: rst=1 mid-run -> all outputs 0 same cycle (async); Val_Rn of any reg reads 0 after release.
//  - ADD R1,R2,R3 (E0821003), R2=5,R3=7 -> next edge WB_EN=1, EXE_CMD=0010, Val_Rn=5, Val_Rm=7, RegDest=1.
//  - Bypass: WB writes R2=0x55 same cycle as decode reading R2 -> Val_Rn=0x55; BYPASS_EN=0 -> old value.
//  - Cond fail: ADDEQ with Z=0 -> control 0, valid_out=0; Z=1 -> WB_EN=1.
//  - Freeze 3 cycles with new instructions in -> outputs unchanged; WB to R4 during freeze visible after.
//  - hazard then flush+hazard same cycle -> two bubbles, bubble_cnt +2; PERF_W=2 saturates at 3.

Source files
------------

// File: rtl/id_pkg.sv
// Decode-stage shared definitions: ALU command codes, instruction field encodings,
// and the decoded control bundle carried through the ID/EX register.
package id_pkg;

  // ALU commands presented to EXE
  localparam logic [3:0] EXE_MOV  = 4'b0001;
  localparam logic [3:0] EXE_MVN  = 4'b1001;
  localparam logic [3:0] EXE_ADD  = 4'b0010;
  localparam logic [3:0] EXE_ADC  = 4'b0011;
  localparam logic [3:0] EXE_SUB  = 4'b0100;
  localparam logic [3:0] EXE_SBC  = 4'b0101;
  localparam logic [3:0] EXE_AND  = 4'b0110;
  localparam logic [3:0] EXE_ORR  = 4'b0111;
  localparam logic [3:0] EXE_EOR  = 4'b1000;
  localparam logic [3:0] EXE_LDST = 4'b0010;  // address = Rn + offset

  // Data-processing opcodes (instr[24:21])
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // Instruction class (instr[27:26])
  localparam logic [1:0] MODE_ALU = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  // Condition codes (instr[31:28])
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       b;
    logic       s;
    logic [3:0] exe_cmd;
  } ctrl_t;

endpackage

// File: rtl/id_regfile.sv
// Architectural register file: async-reset storage, write on rising edge,
// combinational reads with optional same-cycle write-through forwarding.
module id_regfile
  import id_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 16,
  parameter int BYPASS_EN = 1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [3:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        raddr1,
  input  logic [3:0]        raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  localparam int REG_AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [NUM_REGS-1:0][DATA_W-1:0] mem;
  logic w_ok, byp1, byp2;

  // addresses beyond NUM_REGS are neither written nor forwarded; they read as 0
  assign w_ok = we && (int'(waddr) < NUM_REGS);
  assign byp1 = (BYPASS_EN != 0) && w_ok && (waddr == raddr1);
  assign byp2 = (BYPASS_EN != 0) && w_ok && (waddr == raddr2);

  // storage update from write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       mem <= '0;
    else if (w_ok) mem[waddr[REG_AW-1:0]] <= wdata;
  end

  assign rdata1 = byp1 ? wdata : (int'(raddr1) < NUM_REGS) ? mem[raddr1[REG_AW-1:0]] : '0;
  assign rdata2 = byp2 ? wdata : (int'(raddr2) < NUM_REGS) ? mem[raddr2[REG_AW-1:0]] : '0;

endmodule

// File: rtl/id_stage_pipelined.sv
// ARM decode stage with the ID/EX register folded in: field extraction, control
// decode, condition check, register read, and freeze/hazard/flush handling.
module id_stage_pipelined
  import id_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 16,
  parameter int BYPASS_EN = 1,
  parameter int PERF_W    = 16
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] PC_in,
  input  logic              valid_in,
  input  logic              freeze,
  input  logic              hazard,
  input  logic              flush,
  input  logic [3:0]        Status_Reg,
  input  logic              writeBackEn,
  input  logic [3:0]        Dest_wb,
  input  logic [DATA_W-1:0] Result_WB,
  output logic [3:0]        Reg_File_src_1,
  output logic [3:0]        Reg_File_src_2,
  output logic              two_src,
  output logic              WB_EN,
  output logic              MEM_R_EN,
  output logic              MEM_W_EN,
  output logic              B,
  output logic              S,
  output logic [3:0]        EXE_CMD,
  output logic [DATA_W-1:0] Val_Rn,
  output logic [DATA_W-1:0] Val_Rm,
  output logic              imm,
  output logic [11:0]       shifter_operand,
  output logic [23:0]       Signed_imm_24,
  output logic [3:0]        RegDest,
  output logic [3:0]        src1_q,
  output logic [3:0]        src2_q,
  output logic [DATA_W-1:0] PC,
  output logic              valid_out,
  output logic [PERF_W-1:0] bubble_cnt
);
  logic [3:0]        cond, opcode;
  logic [1:0]        mode;
  logic              s_bit, cond_pass, kill;
  logic              n_f, z_f, c_f, v_f;
  logic [DATA_W-1:0] rn_val, rm_val;
  ctrl_t             ctrl, ex_ctrl;

  assign cond   = instruction[31:28];
  assign mode   = instruction[27:26];
  assign opcode = instruction[24:21];
  assign s_bit  = instruction[20];
  assign {n_f, z_f, c_f, v_f} = Status_Reg;

  // stores read Rd as the second source (the data to be written)
  assign Reg_File_src_1 = instruction[19:16];
  assign Reg_File_src_2 = (mode == MODE_MEM && !s_bit) ? instruction[15:12] : instruction[3:0];
  assign two_src        = !(mode == MODE_ALU && (opcode == OP_MOV || opcode == OP_MVN));

  // control decode; undefined encodings fall back to an all-zero bundle
  always_comb begin
    ctrl = '0;
    case (mode)
      MODE_ALU: begin
        ctrl.wb_en = 1'b1;
        ctrl.s     = s_bit;
        case (opcode)
          OP_MOV:  ctrl.exe_cmd = EXE_MOV;
          OP_MVN:  ctrl.exe_cmd = EXE_MVN;
          OP_ADD:  ctrl.exe_cmd = EXE_ADD;
          OP_ADC:  ctrl.exe_cmd = EXE_ADC;
          OP_SUB:  ctrl.exe_cmd = EXE_SUB;
          OP_SBC:  ctrl.exe_cmd = EXE_SBC;
          OP_AND:  ctrl.exe_cmd = EXE_AND;
          OP_ORR:  ctrl.exe_cmd = EXE_ORR;
          OP_EOR:  ctrl.exe_cmd = EXE_EOR;
          OP_CMP:  begin ctrl.exe_cmd = EXE_SUB; ctrl.wb_en = 1'b0; ctrl.s = 1'b1; end
          OP_TST:  begin ctrl.exe_cmd = EXE_AND; ctrl.wb_en = 1'b0; ctrl.s = 1'b1; end
          default: ctrl = '0;
        endcase
      end
      MODE_MEM: begin
        ctrl.exe_cmd  = EXE_LDST;
        ctrl.mem_r_en = s_bit;
        ctrl.wb_en    = s_bit;
        ctrl.mem_w_en = !s_bit;
      end
      MODE_BR:  ctrl.b = 1'b1;
      default:  ctrl = '0;
    endcase
  end

  // condition evaluation against NZCV; 1111 never executes
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      COND_EQ: cond_pass = z_f;
      COND_NE: cond_pass = !z_f;
      COND_CS: cond_pass = c_f;
      COND_CC: cond_pass = !c_f;
      COND_MI: cond_pass = n_f;
      COND_PL: cond_pass = !n_f;
      COND_VS: cond_pass = v_f;
      COND_VC: cond_pass = !v_f;
      COND_HI: cond_pass = c_f && !z_f;
      COND_LS: cond_pass = !c_f || z_f;
      COND_GE: cond_pass = (n_f == v_f);
      COND_LT: cond_pass = (n_f != v_f);
      COND_GT: cond_pass = !z_f && (n_f == v_f);
      COND_LE: cond_pass = z_f || (n_f != v_f);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign kill = !valid_in || !cond_pass || hazard || flush;

  id_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .BYPASS_EN(BYPASS_EN)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (writeBackEn),
    .waddr  (Dest_wb),
    .wdata  (Result_WB),
    .raddr1 (Reg_File_src_1),
    .raddr2 (Reg_File_src_2),
    .rdata1 (rn_val),
    .rdata2 (rm_val)
  );

  // ID/EX register: freeze holds everything; a killed slot clears only control/valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_ctrl         <= '0;
      valid_out       <= 1'b0;
      Val_Rn          <= '0;
      Val_Rm          <= '0;
      imm             <= 1'b0;
      shifter_operand <= '0;
      Signed_imm_24   <= '0;
      RegDest         <= '0;
      src1_q          <= '0;
      src2_q          <= '0;
      PC              <= '0;
    end else if (!freeze) begin
      ex_ctrl         <= kill ? '0 : ctrl;
      valid_out       <= !kill;
      Val_Rn          <= rn_val;
      Val_Rm          <= rm_val;
      imm             <= instruction[25];
      shifter_operand <= instruction[11:0];
      Signed_imm_24   <= instruction[23:0];
      RegDest         <= instruction[15:12];
      src1_q          <= Reg_File_src_1;
      src2_q          <= Reg_File_src_2;
      PC              <= PC_in;
    end
  end

  // saturating count of real instructions squashed by hazard or flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bubble_cnt <= '0;
    else if (!freeze && valid_in && (hazard || flush) && (bubble_cnt != '1))
      bubble_cnt <= bubble_cnt + PERF_W'(1);
  end

  assign WB_EN    = ex_ctrl.wb_en;
  assign MEM_R_EN = ex_ctrl.mem_r_en;
  assign MEM_W_EN = ex_ctrl.mem_w_en;
  assign B        = ex_ctrl.b;
  assign S        = ex_ctrl.s;
  assign EXE_CMD  = ex_ctrl.exe_cmd;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Self-checking bench: two instances (bypass on / 16-bit counter, bypass off /
// 2-bit counter) driven in parallel and compared against a table-driven model.
module tb_id_stage_pipelined;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction, PC_in, Result_WB;
  logic        valid_in, freeze, hazard, flush, writeBackEn;
  logic [3:0]  Status_Reg, Dest_wb;

  // instance A outputs
  logic [3:0]  src1_a, src2_a, cmd_a, rd_a, s1q_a, s2q_a;
  logic        two_src_a, wb_a, mr_a, mw_a, b_a, s_a, imm_a, v_a;
  logic [31:0] vrn_a, vrm_a, pc_a;
  logic [11:0] sh_a;
  logic [23:0] simm_a;
  logic [15:0] bub_a;
  // instance B outputs
  logic [3:0]  src1_b, src2_b, cmd_b, rd_b, s1q_b, s2q_b;
  logic        two_src_b, wb_b, mr_b, mw_b, b_b, s_b, imm_b, v_b;
  logic [31:0] vrn_b, vrm_b, pc_b;
  logic [11:0] sh_b;
  logic [23:0] simm_b;
  logic [1:0]  bub_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_stage_pipelined #(.DATA_W(32), .NUM_REGS(16), .BYPASS_EN(1), .PERF_W(16)) dut_a (
    .clk(clk), .rst(rst), .instruction(instruction), .PC_in(PC_in), .valid_in(valid_in),
    .freeze(freeze), .hazard(hazard), .flush(flush), .Status_Reg(Status_Reg),
    .writeBackEn(writeBackEn), .Dest_wb(Dest_wb), .Result_WB(Result_WB),
    .Reg_File_src_1(src1_a), .Reg_File_src_2(src2_a), .two_src(two_src_a),
    .WB_EN(wb_a), .MEM_R_EN(mr_a), .MEM_W_EN(mw_a), .B(b_a), .S(s_a), .EXE_CMD(cmd_a),
    .Val_Rn(vrn_a), .Val_Rm(vrm_a), .imm(imm_a), .shifter_operand(sh_a),
    .Signed_imm_24(simm_a), .RegDest(rd_a), .src1_q(s1q_a), .src2_q(s2q_a),
    .PC(pc_a), .valid_out(v_a), .bubble_cnt(bub_a)
  );

  id_stage_pipelined #(.DATA_W(32), .NUM_REGS(16), .BYPASS_EN(0), .PERF_W(2)) dut_b (
    .clk(clk), .rst(rst), .instruction(instruction), .PC_in(PC_in), .valid_in(valid_in),
    .freeze(freeze), .hazard(hazard), .flush(flush), .Status_Reg(Status_Reg),
    .writeBackEn(writeBackEn), .Dest_wb(Dest_wb), .Result_WB(Result_WB),
    .Reg_File_src_1(src1_b), .Reg_File_src_2(src2_b), .two_src(two_src_b),
    .WB_EN(wb_b), .MEM_R_EN(mr_b), .MEM_W_EN(mw_b), .B(b_b), .S(s_b), .EXE_CMD(cmd_b),
    .Val_Rn(vrn_b), .Val_Rm(vrm_b), .imm(imm_b), .shifter_operand(sh_b),
    .Signed_imm_24(simm_b), .RegDest(rd_b), .src1_q(s1q_b), .src2_q(s2q_b),
    .PC(pc_b), .valid_out(v_b), .bubble_cnt(bub_b)
  );

  // ---------------- reference model ----------------
  logic [4:0]  alu_tab [16];   // {defined, cmd} per data-processing opcode
  logic [31:0] m_rf [16];
  logic [8:0]  e_ctl;          // {wb, mem_r, mem_w, b, s, cmd}
  logic [80:0] e_data;         // {imm, sh, simm, rd, src1, src2, pc}
  logic [31:0] e_vrn_a, e_vrm_a, e_vrn_b, e_vrm_b;
  logic        e_v;
  int          e_bub_a, e_bub_b;

  initial begin
    for (int i = 0; i < 16; i++) alu_tab[i] = 5'h00;
    alu_tab[4'hD] = 5'h11; alu_tab[4'hF] = 5'h19; alu_tab[4'h4] = 5'h12;
    alu_tab[4'h5] = 5'h13; alu_tab[4'h2] = 5'h14; alu_tab[4'h6] = 5'h15;
    alu_tab[4'h0] = 5'h16; alu_tab[4'hC] = 5'h17; alu_tab[4'h1] = 5'h18;
    alu_tab[4'hA] = 5'h14; alu_tab[4'h8] = 5'h16;
  end

  function automatic logic [8:0] ref_ctl(input logic [31:0] ins);
    logic [3:0] op;
    logic       cmp;
    op = ins[24:21];
    case (ins[27:26])
      2'b00: begin
        if (!alu_tab[op][4]) return 9'h0;
        cmp = (op == 4'hA) || (op == 4'h8);
        return {!cmp, 1'b0, 1'b0, 1'b0, ins[20] | cmp, alu_tab[op][3:0]};
      end
      2'b01:   return {ins[20], ins[20], !ins[20], 1'b0, 1'b0, 4'b0010};
      2'b10:   return {5'b00010, 4'b0000};
      default: return 9'h0;
    endcase
  endfunction

  // even codes are a base predicate, odd codes its inverse
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] st);
    logic p [8];
    p[0] = st[2]; p[1] = st[1]; p[2] = st[3]; p[3] = st[0];
    p[4] = st[1] & ~st[2];
    p[5] = (st[3] == st[0]);
    p[6] = ~st[2] & (st[3] == st[0]);
    p[7] = 1'b1;
    return p[c[3:1]] ^ c[0];
  endfunction

  function automatic logic [3:0] ref_src2(input logic [31:0] ins);
    return (ins[27:26] == 2'b01 && !ins[20]) ? ins[15:12] : ins[3:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    e_ctl = '0; e_data = '0; e_v = 1'b0;
    e_vrn_a = '0; e_vrm_a = '0; e_vrn_b = '0; e_vrm_b = '0;
    e_bub_a = 0; e_bub_b = 0;
  endtask

  // advance the model across one rising edge using the currently driven inputs
  task automatic model_edge();
    logic [3:0] rn, s2;
    logic       kill;
    if (!freeze) begin
      rn   = instruction[19:16];
      s2   = ref_src2(instruction);
      kill = !valid_in || !ref_cond(instruction[31:28], Status_Reg) || hazard || flush;
      e_ctl   = kill ? 9'h0 : ref_ctl(instruction);
      e_v     = !kill;
      e_vrn_b = m_rf[rn];
      e_vrm_b = m_rf[s2];
      e_vrn_a = (writeBackEn && Dest_wb == rn) ? Result_WB : m_rf[rn];
      e_vrm_a = (writeBackEn && Dest_wb == s2) ? Result_WB : m_rf[s2];
      e_data  = {instruction[25], instruction[11:0], instruction[23:0], instruction[15:12], rn, s2, PC_in};
      if (valid_in && (hazard || flush)) begin
        if (e_bub_a < 65535) e_bub_a++;
        if (e_bub_b < 3)     e_bub_b++;
      end
    end
    if (writeBackEn) m_rf[Dest_wb] = Result_WB;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_regs();
    chk("ctl_a", {wb_a, mr_a, mw_a, b_a, s_a, cmd_a}, e_ctl);
    chk("ctl_b", {wb_b, mr_b, mw_b, b_b, s_b, cmd_b}, e_ctl);
    chk("data_a", {imm_a, sh_a, simm_a, rd_a, s1q_a, s2q_a, pc_a}, e_data);
    chk("data_b", {imm_b, sh_b, simm_b, rd_b, s1q_b, s2q_b, pc_b}, e_data);
    chk("vrn_a", vrn_a, e_vrn_a);
    chk("vrm_a", vrm_a, e_vrm_a);
    chk("vrn_b", vrn_b, e_vrn_b);
    chk("vrm_b", vrm_b, e_vrm_b);
    chk("valid_a", v_a, e_v);
    chk("valid_b", v_b, e_v);
    chk("bub_a", bub_a, e_bub_a);
    chk("bub_b", bub_b, e_bub_b);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {wb_a, mr_a, mw_a, b_a, s_a, cmd_a, wb_b, mr_b, mw_b, b_b, s_b, cmd_b}, 0);
    chk({tag, "_val"}, {vrn_a, vrm_a, vrn_b, vrm_b}, 0);
    chk({tag, "_data"}, {imm_a, sh_a, simm_a, rd_a, s1q_a, s2q_a, pc_a, imm_b, sh_b, simm_b}, 0);
    chk({tag, "_misc"}, {rd_b, s1q_b, s2q_b, pc_b, v_a, v_b, bub_a, bub_b}, 0);
  endtask

  task automatic drive(input logic [31:0] ins, input logic vin, input logic hz, input logic fl,
                       input logic fz, input logic we, input logic [3:0] dst,
                       input logic [31:0] res, input logic [3:0] st);
    instruction = ins; valid_in = vin; hazard = hz; flush = fl; freeze = fz;
    writeBackEn = we; Dest_wb = dst; Result_WB = res; Status_Reg = st;
    PC_in = $urandom;
  endtask

  // one clock: check decode-side outputs, step model, check ID/EX after the edge
  task automatic cyc();
    #1;
    chk("src1", {src1_a, src1_b}, {2{instruction[19:16]}});
    chk("src2", {src2_a, src2_b}, {2{ref_src2(instruction)}});
    chk("two_src", {two_src_a, two_src_b},
        {2{!(instruction[27:26] == 2'b00 && (instruction[24:21] == 4'hD || instruction[24:21] == 4'hF))}});
    model_edge();
    @(posedge clk);
    #1;
    check_regs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    logic [31:0] ins, hold_pc;
    logic [3:0]  dst;
    int          b0;

    rst = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    model_reset();
    #1 chk_zero("rst_init");
    @(posedge clk); #1 chk_zero("rst_hold");
    @(negedge clk); rst = 1'b0;

    // R2=5, R3=7 through write-back with bubbles in decode
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 32'h5, 4'h0); cyc();
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 32'h7, 4'h0); cyc();

    // ADD R1,R2,R3
    drive(32'hE0821003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0); cyc();
    chk("add_wb", wb_a, 1'b1);
    chk("add_cmd", cmd_a, 4'b0010);
    chk("add_rn", vrn_a, 32'h5);
    chk("add_rm", vrm_a, 32'h7);
    chk("add_rd", rd_a, 4'h1);

    // write-through: R2 <- 0x55 in the same cycle it is read
    drive(32'hE0821003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 32'h55, 4'h0); cyc();
    chk("byp_on", vrn_a, 32'h55);
    chk("byp_off", vrn_b, 32'h5);

    // ADDEQ: Z clear then Z set
    drive(32'h00821003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0); cyc();
    chk("eq_fail_v", {v_a, wb_a}, 2'b00);
    drive(32'h00821003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'b0100); cyc();
    chk("eq_pass_wb", wb_a, 1'b1);

    // freeze for three cycles while fresh instructions arrive and R4 is written
    drive(32'hE0821003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    hold_pc = PC_in;
    cyc();
    for (int i = 0; i < 3; i++) begin
      drive($urandom, 1'b1, 1'b0, 1'b0, 1'b1, (i == 1), 4'h4, 32'h1234, 4'h0);
      cyc();
      chk("frz_pc", pc_a, hold_pc);
    end
    drive(32'hE0840004, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0); cyc();
    chk("frz_wb_r4", vrn_a, 32'h1234);

    // hazard, then flush+hazard, then saturate the narrow counter
    b0 = e_bub_a;
    drive(32'hE0821003, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0); cyc();
    drive(32'hE0821003, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0); cyc();
    chk("bub_plus2", bub_a, b0 + 2);
    chk("bub_killed", {v_a, wb_a}, 2'b00);
    for (int i = 0; i < 2; i++) begin
      drive(32'hE0821003, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0); cyc();
    end
    chk("bub_sat", bub_b, 2'd3);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int r;
      r   = $urandom_range(0, 9);
      ins = $urandom;
      ins[27:26] = (r < 6) ? 2'b00 : (r < 8) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      if ($urandom_range(0, 9) < 7) ins[31:28] = 4'hE;
      dst = ($urandom_range(0, 3) == 0) ? ins[19:16] : 4'($urandom);
      drive(ins, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
            1'($urandom), dst, $urandom, 4'($urandom));
      cyc();
    end

    // asynchronous reset mid-cycle, including while frozen
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 4'h0);
    #2 rst = 1'b1;
    #1 chk_zero("rst_async");
    model_reset();
    @(posedge clk); #1 chk_zero("rst_mid_hold");
    @(negedge clk); rst = 1'b0;
    drive(32'hE0851006, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0); cyc();
    chk("post_rst_r5", {vrn_a, vrn_b}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
